// File: rtl/rob_commit_pkg.sv
// rtl/rob_commit_pkg.sv - shared widths, constants and helpers for the reorder buffer
package rob_commit_pkg;

    localparam int REG_LEN      = 32;
    localparam int REG_ADDR_LEN = 5;
    localparam int ROB_DEPTH_DEFAULT = 16;

    localparam logic [REG_LEN-1:0]      ZERO_WORD     = '0;
    localparam logic [REG_ADDR_LEN-1:0] REG_ADDR_ZERO = '0;
    localparam logic                    WRITE_ENABLE  = 1'b1;

    // x0 is hard-wired, so a commit to it must not raise the write strobe
    function automatic logic writes_reg(input logic [REG_ADDR_LEN-1:0] rd);
        return (rd != REG_ADDR_ZERO) ? WRITE_ENABLE : 1'b0;
    endfunction

endpackage

// File: rtl/rob_ptr_ctrl.sv
// rtl/rob_ptr_ctrl.sv - head/tail/count bookkeeping for the reorder buffer, with flush clear
module rob_ptr_ctrl #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_fire,
    input  logic             commit_fire,
    input  logic             flush,
    output logic [TAG_W-1:0] head,
    output logic [TAG_W-1:0] tail,
    output logic             full,
    output logic             empty
);

    localparam logic [TAG_W:0] DEPTH_CNT = (TAG_W+1)'(ROB_DEPTH);

    logic [TAG_W:0] count;

    // Pointers wrap naturally; full/empty are decided by count alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (alloc_fire)
                tail <= tail + TAG_W'(1);
            if (commit_fire)
                head <= head + TAG_W'(1);
            count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(commit_fire);
        end
    end

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

endmodule

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order commit stage driving the reg-file write port
// Optional operand lookup ports for decode are enabled by defining ROB_QUERY_EN.
module rob_commit
    import rob_commit_pkg::*;
#(
    parameter int ROB_DEPTH = ROB_DEPTH_DEFAULT,
    parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    alloc_valid,
    input  logic [REG_ADDR_LEN-1:0] alloc_rd,
    output logic                    alloc_ready,
    output logic [TAG_W-1:0]        alloc_tag,
    input  logic                    cdb_valid,
    input  logic [TAG_W-1:0]        cdb_tag,
    input  logic [REG_LEN-1:0]      cdb_value,
    input  logic                    cdb_mispredict,
    input  logic [REG_LEN-1:0]      cdb_target,
    output logic                    write_enable,
    output logic [REG_ADDR_LEN-1:0] write_addr,
    output logic [REG_LEN-1:0]      write_data,
    output logic                    failed,
    output logic [REG_LEN-1:0]      redirect_pc,
    output logic                    empty
`ifdef ROB_QUERY_EN
    ,
    input  logic [TAG_W-1:0]        qry_tag1,
    output logic                    qry_done1,
    output logic [REG_LEN-1:0]      qry_value1,
    input  logic [TAG_W-1:0]        qry_tag2,
    output logic                    qry_done2,
    output logic [REG_LEN-1:0]      qry_value2
`endif
);

    logic [ROB_DEPTH-1:0]    valid;
    logic [ROB_DEPTH-1:0]    done;
    logic [REG_ADDR_LEN-1:0] rd_q     [ROB_DEPTH];
    logic [REG_LEN-1:0]      value_q  [ROB_DEPTH];
    logic                    misp_q   [ROB_DEPTH];
    logic [REG_LEN-1:0]      target_q [ROB_DEPTH];

    logic [TAG_W-1:0] head;
    logic [TAG_W-1:0] tail;
    logic             full;
    logic             head_go;
    logic             flush_now;
    logic             alloc_fire;
    logic             cdb_fire;

    assign head_go     = rdy && valid[head] && done[head];
    assign flush_now   = head_go && misp_q[head];
    assign alloc_ready = !full && !flush_now;
    assign alloc_tag   = tail;
    assign alloc_fire  = rdy && alloc_valid && alloc_ready;
    assign cdb_fire    = rdy && cdb_valid && valid[cdb_tag] && !flush_now;

    rob_ptr_ctrl #(
        .ROB_DEPTH (ROB_DEPTH),
        .TAG_W     (TAG_W)
    ) u_ptr (
        .clk         (clk),
        .rst         (rst),
        .alloc_fire  (alloc_fire),
        .commit_fire (head_go),
        .flush       (flush_now),
        .head        (head),
        .tail        (tail),
        .full        (full),
        .empty       (empty)
    );

    // Status bits; completion uses last cycle's done, so a CDB hit on the head commits a cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
            done  <= '0;
        end else if (flush_now) begin
            valid <= '0;
            done  <= '0;
        end else begin
            if (cdb_fire)
                done[cdb_tag] <= 1'b1;
            if (head_go) begin
                valid[head] <= 1'b0;
                done[head]  <= 1'b0;
            end
            if (alloc_fire) begin
                valid[tail] <= 1'b1;
                done[tail]  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire)
            rd_q[tail] <= alloc_rd;
        if (cdb_fire) begin
            value_q[cdb_tag]  <= cdb_value;
            misp_q[cdb_tag]   <= cdb_mispredict;
            target_q[cdb_tag] <= cdb_target;
        end
    end

    // A mispredicted head still performs its own write (e.g. a JALR link)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_enable <= 1'b0;
            write_addr   <= REG_ADDR_ZERO;
            write_data   <= ZERO_WORD;
            failed       <= 1'b0;
            redirect_pc  <= ZERO_WORD;
        end else begin
            write_enable <= 1'b0;
            failed       <= 1'b0;
            if (head_go) begin
                write_enable <= writes_reg(rd_q[head]);
                write_addr   <= rd_q[head];
                write_data   <= value_q[head];
                if (misp_q[head]) begin
                    failed      <= 1'b1;
                    redirect_pc <= target_q[head];
                end
            end
        end
    end

`ifdef ROB_QUERY_EN
    logic qry_block;
    logic qry_fwd1;
    logic qry_fwd2;

    assign qry_block  = flush_now || failed;
    assign qry_fwd1   = cdb_valid && (cdb_tag == qry_tag1);
    assign qry_fwd2   = cdb_valid && (cdb_tag == qry_tag2);
    assign qry_done1  = !qry_block && (qry_fwd1 || (valid[qry_tag1] && done[qry_tag1]));
    assign qry_done2  = !qry_block && (qry_fwd2 || (valid[qry_tag2] && done[qry_tag2]));
    assign qry_value1 = qry_fwd1 ? cdb_value : value_q[qry_tag1];
    assign qry_value2 = qry_fwd2 ? cdb_value : value_q[qry_tag2];
`endif

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - self-checking bench for rob_commit (table vectors + write scoreboard)
module tb_rob_commit;

    localparam int DEPTH = 16;
    localparam int TW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          rdy;
    logic          alloc_valid;
    logic [4:0]    alloc_rd;
    logic          alloc_ready;
    logic [TW-1:0] alloc_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_value;
    logic          cdb_mispredict;
    logic [31:0]   cdb_target;
    logic          write_enable;
    logic [4:0]    write_addr;
    logic [31:0]   write_data;
    logic          failed;
    logic [31:0]   redirect_pc;
    logic          empty;

    rob_commit #(.ROB_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .rdy            (rdy),
        .alloc_valid    (alloc_valid),
        .alloc_rd       (alloc_rd),
        .alloc_ready    (alloc_ready),
        .alloc_tag      (alloc_tag),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_value      (cdb_value),
        .cdb_mispredict (cdb_mispredict),
        .cdb_target     (cdb_target),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .failed         (failed),
        .redirect_pc    (redirect_pc),
        .empty          (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] value;
        int          order;
        bit          exp_we;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    vec_t tbl [6];
    wr_t  sb [$];
    wr_t  mon_e;
    int   errors = 0;
    int   checks = 0;
    int   model_tail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every reg-file write must match the next expected write in order
    always @(posedge clk) begin
        #1;
        if (write_enable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h, expected no write",
                         write_addr, write_data);
            end else begin
                mon_e = sb.pop_front();
                check("write_addr", 32'(write_addr), 32'(mon_e.addr));
                check("write_data", write_data, mon_e.data);
            end
        end
    end

    task automatic do_alloc(input logic [4:0] rd, input logic [31:0] val, input bit push);
        check("alloc_ready", 32'(alloc_ready), 32'd1);
        check("alloc_tag", 32'(alloc_tag), 32'(model_tail));
        alloc_valid = 1'b1;
        alloc_rd    = rd;
        step;
        alloc_valid = 1'b0;
        if (push && rd != 5'd0)
            sb.push_back('{addr: rd, data: val});
        model_tail = (model_tail + 1) % DEPTH;
    endtask

    task automatic do_cdb(input int tag, input logic [31:0] val, input logic misp, input logic [31:0] tgt);
        cdb_valid      = 1'b1;
        cdb_tag        = TW'(tag);
        cdb_value      = val;
        cdb_mispredict = misp;
        cdb_target     = tgt;
        step;
        cdb_valid      = 1'b0;
        cdb_mispredict = 1'b0;
    endtask

    task automatic wait_empty(input int budget, input string name);
        int n = 0;
        while (empty !== 1'b1 && n < budget) begin
            step;
            n++;
        end
        check(name, 32'(empty), 32'd1);
    endtask

    initial begin
        int base;
        int j;
        bit lat;

        tbl[0] = '{rd: 5'd3, value: 32'h11, order: 0, exp_we: 1'b1};
        tbl[1] = '{rd: 5'd5, value: 32'h22, order: 1, exp_we: 1'b1};
        tbl[2] = '{rd: 5'd0, value: 32'h33, order: 2, exp_we: 1'b0};
        tbl[3] = '{rd: 5'd7, value: 32'ha1, order: 2, exp_we: 1'b1};
        tbl[4] = '{rd: 5'd8, value: 32'hb2, order: 1, exp_we: 1'b1};
        tbl[5] = '{rd: 5'd9, value: 32'hc3, order: 0, exp_we: 1'b1};

        rst = 1'b1; rdy = 1'b1;
        alloc_valid = 1'b0; alloc_rd = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0; cdb_mispredict = 1'b0; cdb_target = '0;
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_alloc_ready", 32'(alloc_ready), 32'd1);
        check("rst_alloc_tag", 32'(alloc_tag), 32'd0);
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_write_addr", 32'(write_addr), 32'd0);
        check("rst_write_data", write_data, 32'd0);
        check("rst_failed", 32'(failed), 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        step;
        step;
        rst = 1'b0;

        // Table groups: in-order completion, then reversed completion
        for (int g = 0; g < 2; g++) begin
            base = model_tail;
            for (int i = 0; i < 3; i++)
                do_alloc(tbl[g*3+i].rd, tbl[g*3+i].value, tbl[g*3+i].exp_we);
            lat = 1'b0;
            for (int k = 0; k < 3; k++) begin
                j = 0;
                for (int i = 0; i < 3; i++)
                    if (tbl[g*3+i].order == k) j = i;
                do_cdb(base + j, tbl[g*3+j].value, 1'b0, 32'd0);
                if (lat) begin
                    check("latency_n2_we", 32'(write_enable), 32'd1);
                    lat = 1'b0;
                end
                if (j == 0) begin
                    check("latency_n1_we", 32'(write_enable), 32'd0);
                    lat = 1'b1;
                end
            end
            if (lat) begin
                step;
                check("latency_n2_we", 32'(write_enable), 32'd1);
            end
            wait_empty(10, "table_drain_empty");
        end

        // Reset mid-operation with 5 entries outstanding
        for (int i = 0; i < 5; i++)
            do_alloc(5'(i + 1), 32'd0, 1'b0);
        check("mid_not_empty", 32'(empty), 32'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_alloc_tag", 32'(alloc_tag), 32'd0);
        check("mid_rst_we", 32'(write_enable), 32'd0);
        sb.delete();
        step;
        rst = 1'b0;
        model_tail = 0;

        // Fill to full, free one slot, wrap the tail
        for (int i = 0; i < DEPTH; i++)
            do_alloc(5'(i + 1), 32'h100 + 32'(i), 1'b1);
        check("full_alloc_ready", 32'(alloc_ready), 32'd0);
        do_cdb(0, 32'h100, 1'b0, 32'd0);
        check("full_commit_pending_ready", 32'(alloc_ready), 32'd0);
        step;
        check("after_commit_ready", 32'(alloc_ready), 32'd1);
        check("wrap_alloc_tag", 32'(alloc_tag), 32'd0);
        for (int t = 1; t < DEPTH; t++)
            do_cdb(t, 32'h100 + 32'(t), 1'b0, 32'd0);
        wait_empty(40, "full_drain_empty");
        step;
        check("full_sb_drained", 32'(sb.size()), 32'd0);

        // Mispredict on entry 1: its link write lands, entry 2 is squashed
        do_alloc(5'd1, 32'h44, 1'b1);
        do_alloc(5'd2, 32'h55, 1'b1);
        do_alloc(5'd4, 32'h66, 1'b0);
        do_cdb(2, 32'h66, 1'b0, 32'd0);
        do_cdb(1, 32'h55, 1'b1, 32'h100);
        do_cdb(0, 32'h44, 1'b0, 32'd0);
        begin
            int n = 0;
            while (failed !== 1'b1 && n < 10) begin
                step;
                n++;
            end
        end
        check("failed_pulse", 32'(failed), 32'd1);
        check("redirect_pc", redirect_pc, 32'h100);
        step;
        check("failed_one_cycle", 32'(failed), 32'd0);
        check("flush_empty", 32'(empty), 32'd1);
        check("flush_alloc_tag", 32'(alloc_tag), 32'd0);
        step;
        step;
        model_tail = 0;

        // rdy stall with a completed head
        do_alloc(5'd9, 32'h77, 1'b1);
        do_cdb(0, 32'h77, 1'b0, 32'd0);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            check("stall_no_write", 32'(write_enable), 32'd0);
        end
        check("stall_not_empty", 32'(empty), 32'd0);
        rdy = 1'b1;
        step;
        check("resume_write", 32'(write_enable), 32'd1);
        step;
        check("resume_empty", 32'(empty), 32'd1);
        check("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
